// File: rtl/asmd_multiplier_if.sv
// Operand/result bundle for asmd_multiplier: the master drives operands and start,
// the slave returns product and ready.
interface asmd_multiplier_if #(
  parameter int word_length = 8
) ();
  logic [word_length-1:0]   word0;
  logic [word_length-1:0]   word1;
  logic                     start;
  logic [2*word_length-1:0] product;
  logic                     ready;

  modport master (output word0, output word1, output start,
                  input  product, input ready);
  modport slave  (input  word0, input word1, input start,
                  output product, output ready);
endinterface

// File: rtl/asmd_multiplier.sv
// Unsigned ASMD shift-add multiplier (S_IDLE / S_ADD / S_SHIFT), two cycles per multiplier bit.
// Optional feature macro ASMD_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module asmd_multiplier #(
  parameter int word_length = 8
) (
  input  logic               clk,
  input  logic               reset,
  asmd_multiplier_if.slave   bus
);
  localparam int W     = word_length;
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_SHIFT = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2*W-1:0]   r_multiplicand;
  logic [W-1:0]     r_multiplier;
  logic [2*W-1:0]   r_product;
  logic [CNT_W-1:0] r_counter;
  logic             w_last;
  logic             w_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

`ifdef ASMD_MULT_EARLY_EXIT_EN
  // Stop once no set bits remain after this shift; the counter still bounds the loop.
  assign w_last = (r_counter == LAST_CNT) || ((r_multiplier >> 1) == '0);
`else
  assign w_last = (r_counter == LAST_CNT);
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_ADD;
      S_ADD:   w_next_state = S_SHIFT;
      S_SHIFT: w_next_state = w_last ? S_IDLE : S_ADD;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state == S_IDLE);
  end

  // Datapath: operands are captured only on the accepting edge; idle without start holds all.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_product      <= '0;
      r_counter      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_multiplicand <= {{W{1'b0}}, bus.word0};
          r_multiplier   <= bus.word1;
          r_product      <= '0;
          r_counter      <= '0;
        end
        S_ADD: if (r_multiplier[0]) r_product <= r_product + r_multiplicand;
        S_SHIFT: begin
          r_multiplicand <= r_multiplicand << 1;
          r_multiplier   <= r_multiplier >> 1;
          r_counter      <= r_counter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.ready   = w_ready;
endmodule

// File: tb/tb_asmd_multiplier.sv
// Directed-vector bench for asmd_multiplier (W=8); honours ASMD_MULT_EARLY_EXIT_EN for latency expectations.
module tb_asmd_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  asmd_multiplier_if #(.word_length(W)) bus ();

  asmd_multiplier #(.word_length(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef ASMD_MULT_EARLY_EXIT_EN
    int h = 0;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return 2 * (h + 1);
`else
    return 2 * W;
`endif
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges after the accepting edge until ready is seen, bounded.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.ready && cyc < 200);
  endtask

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    bus.word0 = a;
    bus.word1 = b;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_ready(cyc);
    check({tag, "_lat"}, cyc, exp_latency(b));
    check({tag, "_prod"}, bus.product, 64'(a) * 64'(b));
  endtask

  initial begin
    int cyc;
    bus.word0 = '0;
    bus.word1 = '0;
    bus.start = 1'b0;
    reset     = 1'b1;
    step(2);
    check("rst_prod", bus.product, 0);
    check("rst_ready", bus.ready, 1);
    reset = 1'b0;
    step(10);
    check("idle_prod", bus.product, 0);
    check("idle_ready", bus.ready, 1);

    run_mult("m5x7", 8'd5, 8'd7);
    bus.word0 = 8'd99;
    bus.word1 = 8'd42;
    step(5);
    check("hold_prod", bus.product, 35);
    check("hold_ready", bus.ready, 1);

    run_mult("m255x255", 8'd255, 8'd255);
    run_mult("m0x200", 8'd0, 8'd200);
    run_mult("m200x0", 8'd200, 8'd0);

    // Start pulse and operand change mid-operation must be ignored.
    bus.word0 = 8'd12;
    bus.word1 = 8'd10;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(2);
    bus.word0 = 8'd3;
    bus.word1 = 8'd3;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_ready(cyc);
    check("busy_lat", cyc + 3, exp_latency(8'd10));
    check("busy_prod", bus.product, 120);

    // Reset mid-operation aborts.
    bus.word0 = 8'd9;
    bus.word1 = 8'd9;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(5);
    check("abort_busy", bus.ready, 0);
    reset = 1'b1;
    step(1);
    check("abort_prod", bus.product, 0);
    check("abort_ready", bus.ready, 1);
    reset = 1'b0;
    run_mult("m6x4", 8'd6, 8'd4);

    // Continuous start restarts on the first idle cycle.
    bus.word0 = 8'd3;
    bus.word1 = 8'd5;
    bus.start = 1'b1;
    step(1);
    wait_ready(cyc);
    check("cont_lat", cyc, exp_latency(8'd5));
    check("cont_prod", bus.product, 15);
    step(1);
    check("cont_restart", bus.ready, 0);
    bus.start = 1'b0;
    wait_ready(cyc);
    check("cont_prod2", bus.product, 15);

    run_mult("m100x1", 8'd100, 8'd1);
    run_mult("m100x128", 8'd100, 8'h80);
    run_mult("m1x255", 8'd1, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/asmd_multiplier.md
ASMD_MULTIPLIER -- requirements
Module: asmd_multiplier

Interface
REQ-001 Parameter word_length, default 8, operand width W in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 word0  input  W  unsigned multiplicand.
REQ-005 word1  input  W  unsigned multiplier.
REQ-006 start  input  1  request to begin a multiplication.
REQ-007 product  output  2W  unsigned result register.
REQ-008 ready  output  1  high when idle and product is valid.

Function
REQ-009 The block SHALL be an ASMD shift-add unit with states S_IDLE, S_ADD, S_SHIFT.
REQ-010 ready SHALL be a Moore output, 1 exactly when state is S_IDLE.
REQ-011 In S_IDLE with start=1 on a rising edge: multiplicand reg <= {W'b0, word0}, multiplier reg <= word1, product <= 0, counter <= 0, state -> S_ADD.
REQ-012 In S_IDLE with start=0: all registers SHALL hold, so product stays stable.
REQ-013 S_ADD: if multiplier[0]=1, product <= product + multiplicand (2W-bit, no overflow possible); state -> S_SHIFT.
REQ-014 S_SHIFT: multiplicand <<= 1, multiplier >>= 1, counter += 1; if counter = W-1, state -> S_IDLE, else -> S_ADD.
REQ-015 Operands SHALL be sampled only at the accepting edge; later changes to word0/word1 have no effect.
REQ-016 start while not in S_IDLE SHALL be ignored.
REQ-017 Latency: with start accepted at edge k, ready SHALL reassert after edge k+2W and product = word0*word1 from then until the next accepted start.
REQ-018 product contents while ready=0 are intermediate and SHALL NOT be relied on.
REQ-019 start held high continuously SHALL restart on the first S_IDLE cycle; product is valid for exactly that one ready cycle.
REQ-020 Arithmetic SHALL be unsigned; 0 operands yield product 0 with normal latency.
REQ-021 Counter width SHALL be clog2(W)+1 bits.

Reset
REQ-022 reset=1 at a rising edge SHALL force state S_IDLE, product 0, multiplicand/multiplier/counter 0, hence ready=1.
REQ-023 reset SHALL take priority over start and over any in-progress operation (mid-operation abort, no partial result kept).
REQ-024 The first start after reset release SHALL be accepted normally.

Configuration
REQ-025 Macro ASMD_MULT_EARLY_EXIT_EN: when defined, S_SHIFT SHALL go to S_IDLE if the shifted multiplier equals 0 (or counter = W-1), giving latency 2*(index of highest set bit of word1 + 1), minimum 2 cycles (word1 = 0 or 1).
REQ-026 When ASMD_MULT_EARLY_EXIT_EN is not defined, latency SHALL be fixed at 2W cycles per REQ-017; results identical in both builds.

Verification (W=8)
REQ-027 Assert reset 2 cycles -> product=0, ready=1; release, start=0 10 cycles -> unchanged.
REQ-028 word0=5, word1=7, start 1 cycle -> ready low 16 cycles, then ready=1, product=35, held while start=0.
REQ-029 word0=255, word1=255 -> product=65025; word0=0, word1=200 -> product=0; word0=200, word1=0 -> product=0.
REQ-030 word0=12, word1=10 started, pulse start with word0=3, word1=3 mid-operation and change operands -> ignored, product=120.
REQ-031 Start 9*9, assert reset at cycle 6 -> next edge product=0, ready=1; then 6*4 -> product=24 after 16 cycles.
REQ-032 With ASMD_MULT_EARLY_EXIT_EN: word0=100, word1=1 -> ready after 2 cycles, product=100; word1=0x80 -> 16 cycles, product=12800.
